// File: rtl/bullet_pool_ctrl_if.sv
// Bullet pool bus: frame/fire/collision inputs and the merged bullet layer.
//   master : input/collision/compositor side (drives fsync, fire, player_x,
//            hit, hpos, vpos; observes the bullet layer and spawn status)
//   slave  : bullet_pool_ctrl side
interface bullet_pool_ctrl_if #(
  parameter int unsigned NUM_SLOTS = 4
);
  localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic                  fsync;
  logic                  fire;
  logic signed [11:0]    player_x;
  logic [NUM_SLOTS-1:0]  hit;
  logic signed [11:0]    hpos;
  logic signed [11:0]    vpos;
  logic [NUM_SLOTS-1:0]  slot_active;
  logic                  active;
  logic [SW-1:0]         active_slot;
  logic [0:2][7:0]       pixel;        // pixel[2]=R, pixel[1]=G, pixel[0]=B
  logic                  fire_accepted;
  logic [15:0]           shots_fired;

  modport master (
    output fsync, fire, player_x, hit, hpos, vpos,
    input  slot_active, active, active_slot, pixel, fire_accepted, shots_fired
  );

  modport slave (
    input  fsync, fire, player_x, hit, hpos, vpos,
    output slot_active, active, active_slot, pixel, fire_accepted, shots_fired
  );
endinterface

// File: rtl/bullet_pool_ctrl.sv
// bullet_pool_ctrl: multi-slot player bullet pool.
// Turns fire presses into rate-limited spawns in the lowest free slot,
// moves every flying bullet up once per frame, frees slots on hit or when
// they leave the top, and draws the merged bullet layer.
// Ports:
//   pixel_clk  sole clock
//   rst        synchronous active-high reset
//   bus        bullet_pool_ctrl_if.slave (fsync, fire, player_x, hit,
//              hpos, vpos in; slot_active, active, active_slot, pixel,
//              fire_accepted, shots_fired out)
module bullet_pool_ctrl #(
  parameter int unsigned NUM_SLOTS       = 4,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int          SPEED           = 4,
  parameter int          BW              = 4,
  parameter int          BH              = 8,
  parameter int          SPAWN_Y         = 456,
  parameter logic [23:0] COLOR           = 24'hFFFF00
) (
  input logic              pixel_clk,
  input logic              rst,
  bullet_pool_ctrl_if.slave bus
);

  localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic signed [11:0] SPEED_S   = 12'(SPEED);
  localparam logic signed [11:0] HALF_W    = 12'(BW >> 1);
  localparam logic signed [11:0] BH_S      = 12'(BH);
  localparam logic signed [11:0] SPAWN_Y_S = 12'(SPAWN_Y);
  localparam logic [3:0]         CD_LOAD   = 4'(COOLDOWN_FRAMES);

  typedef enum logic {
    REQ_IDLE,
    REQ_PENDING
  } req_state_t;

  // Fire front end
  logic [2:0] sync_q;
  logic       hist_q;
  logic       fire_rise;
  req_state_t req_q, req_d;

  // Slot pool
  logic [NUM_SLOTS-1:0] act_q, act_d;
  logic signed [11:0]   x_q [NUM_SLOTS];
  logic signed [11:0]   x_d [NUM_SLOTS];
  logic signed [11:0]   y_q [NUM_SLOTS];
  logic signed [11:0]   y_d [NUM_SLOTS];
  logic [3:0]           cd_q, cd_d;
  logic [15:0]          shots_q, shots_d;
  logic                 acc_q, acc_d;

  logic                 free_found;
  int unsigned          spawn_idx;
  logic                 spawn_ok;
  logic [NUM_SLOTS-1:0] covered;

  assign fire_rise = sync_q[2] & ~hist_q;

  // Request FSM: fsync drops any request, a simultaneous new edge re-arms it
  always_comb begin
    req_d = req_q;
    if (bus.fsync) req_d = REQ_IDLE;
    if (fire_rise) req_d = REQ_PENDING;
  end

  // Lowest free slot, judged on pre-edge occupancy only
  always_comb begin
    free_found = 1'b0;
    spawn_idx  = 0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!act_q[i] && !free_found) begin
        free_found = 1'b1;
        spawn_idx  = i;
      end
    end
  end

  assign spawn_ok = bus.fsync && (req_q == REQ_PENDING) && (cd_q == '0) && free_found;

  always_comb begin
    act_d   = act_q;
    x_d     = x_q;
    y_d     = y_q;
    cd_d    = cd_q;
    shots_d = shots_q;
    acc_d   = 1'b0;
    if (bus.fsync) begin
      if (cd_q != '0) cd_d = cd_q - 4'd1;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (act_q[i]) begin
          if (bus.hit[i])            act_d[i] = 1'b0;
          else if (y_q[i] > SPEED_S) y_d[i]   = y_q[i] - SPEED_S;
          else                       act_d[i] = 1'b0;
        end
        // The spawn target was free pre-edge, so it is never moved or hit here
        if (spawn_ok && (i == spawn_idx)) begin
          act_d[i] = 1'b1;
          x_d[i]   = bus.player_x;
          y_d[i]   = SPAWN_Y_S;
        end
      end
      if (spawn_ok) begin
        cd_d    = CD_LOAD;
        shots_d = shots_q + 16'd1;
        acc_d   = 1'b1;
      end
    end else begin
      act_d = act_q & ~bus.hit;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      req_q   <= REQ_IDLE;
      act_q   <= '0;
      cd_q    <= '0;
      shots_q <= '0;
      acc_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      sync_q  <= {sync_q[1:0], bus.fire};
      hist_q  <= sync_q[2];
      req_q   <= req_d;
      act_q   <= act_d;
      cd_q    <= cd_d;
      shots_q <= shots_d;
      acc_q   <= acc_d;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  assign bus.slot_active   = act_q;
  assign bus.shots_fired   = shots_q;
  assign bus.fire_accepted = acc_q;

  // Draw: inclusive signed box test per slot, lowest covering slot wins
  always_comb begin
    covered         = '0;
    bus.active      = 1'b0;
    bus.active_slot = '0;
    bus.pixel       = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      covered[i] = act_q[i]
                && (bus.hpos >= x_q[i] - HALF_W) && (bus.hpos <= x_q[i] + HALF_W)
                && (bus.vpos >= y_q[i])          && (bus.vpos <= y_q[i] + BH_S);
    end
    for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
      if (covered[i-1]) bus.active_slot = SW'(i - 1);
    end
    bus.active = |covered;
    if (bus.active) begin
      bus.pixel[2] = COLOR[23:16];
      bus.pixel[1] = COLOR[15:8];
      bus.pixel[0] = COLOR[7:0];
    end
  end

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Randomized bench for bullet_pool_ctrl against a frame-level pool model.
module tb_bullet_pool_ctrl;

  localparam int unsigned NS      = 4;
  localparam int          CD      = 2;
  localparam int          SPEED   = 4;
  localparam int          BW      = 4;
  localparam int          BH      = 8;
  localparam int          SPAWN_Y = 40;
  localparam logic [23:0] COLOR   = 24'hFF8000;
  localparam int          FRAME   = 40;
  localparam int          HALF    = BW >> 1;

  logic pixel_clk = 1'b0;
  logic rst;

  always #5 pixel_clk = ~pixel_clk;

  bullet_pool_ctrl_if #(.NUM_SLOTS(NS)) bus ();

  bullet_pool_ctrl #(
    .NUM_SLOTS(NS),
    .COOLDOWN_FRAMES(CD),
    .SPEED(SPEED),
    .BW(BW),
    .BH(BH),
    .SPAWN_Y(SPAWN_Y),
    .COLOR(COLOR)
  ) dut (
    .pixel_clk(pixel_clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference pool state
  bit m_act [NS];
  int m_x   [NS];
  int m_y   [NS];
  int m_cd;
  int m_shots;
  bit m_acc;
  int fire_lvl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  function automatic logic [NS-1:0] pack_act();
    logic [NS-1:0] v;
    v = '0;
    for (int i = 0; i < NS; i++) v[i] = m_act[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0;
      m_x[i]   = 0;
      m_y[i]   = 0;
    end
    m_cd    = 0;
    m_shots = 0;
    m_acc   = 0;
  endtask

  // One frame boundary: moves, cooldown and spawn all judged on pre-boundary state
  task automatic model_fsync(input bit req, input int px, input logic [NS-1:0] hfs);
    int  pick;
    bit  spawn;
    pick = -1;
    for (int i = NS - 1; i >= 0; i--) if (!m_act[i]) pick = i;
    spawn = req && (m_cd == 0) && (pick >= 0);
    for (int i = 0; i < NS; i++) begin
      if (m_act[i]) begin
        if (hfs[i])            m_act[i] = 0;
        else if (m_y[i] > SPEED) m_y[i] = m_y[i] - SPEED;
        else                   m_act[i] = 0;
      end
    end
    if (m_cd > 0) m_cd = m_cd - 1;
    m_acc = spawn;
    if (spawn) begin
      m_act[pick] = 1;
      m_x[pick]   = px;
      m_y[pick]   = SPAWN_Y;
      m_cd        = CD;
      m_shots     = (m_shots + 1) % 65536;
    end
  endtask

  task automatic probe_at(input int h, input int v, input string tag);
    bit a;
    int s;
    a = 0;
    s = 0;
    for (int i = 0; i < NS; i++) begin
      if (m_act[i] && h >= m_x[i] - HALF && h <= m_x[i] + HALF &&
          v >= m_y[i] && v <= m_y[i] + BH && !a) begin
        a = 1;
        s = i;
      end
    end
    bus.hpos = 12'(h);
    bus.vpos = 12'(v);
    #1;
    check({tag, "_active"}, 32'(bus.active), 32'(a));
    check({tag, "_slot"}, 32'(bus.active_slot), 32'(s));
    check({tag, "_pixel"}, 32'({bus.pixel[2], bus.pixel[1], bus.pixel[0]}),
          a ? 32'(COLOR) : 32'd0);
  endtask

  task automatic random_probe();
    int k, h, v;
    k = int'($urandom_range(0, NS - 1));
    if (m_act[k] && $urandom_range(0, 3) != 0) begin
      h = m_x[k] + int'($urandom_range(0, BW + 2)) - (HALF + 1);
      v = m_y[k] + int'($urandom_range(0, BH + 2)) - 1;
    end else begin
      h = int'($urandom_range(0, 660)) - 10;
      v = int'($urandom_range(0, 60)) - 5;
    end
    probe_at(h, v, "draw");
  endtask

  // mode 0: fire low, 1: 10-cycle pulse, 2: hold high
  task automatic run_frame(input int mode, input int px, input logic [NS-1:0] hmid,
                           input logic [NS-1:0] hfs, input bit rst_fs);
    bit press;
    press = (mode != 0) && (fire_lvl == 0);
    bus.player_x = 12'(px);
    for (int c = 0; c < FRAME; c++) begin
      if (c == 2) bus.fire = (mode != 0);
      if (c == 12 && mode == 1) bus.fire = 1'b0;
      bus.hit   = (c == 20) ? hmid : '0;
      bus.fsync = 1'b0;
      if (c == FRAME - 1) begin
        bus.fsync = 1'b1;
        bus.hit   = hfs;
        rst       = rst_fs;
      end
      if (c >= 25 && c < 33) random_probe();
      tick();
      if (c == 20) begin
        for (int i = 0; i < NS; i++) if (hmid[i]) m_act[i] = 0;
        check("slot_active_hit", 32'(bus.slot_active), 32'(pack_act()));
      end
    end
    bus.fsync = 1'b0;
    bus.hit   = '0;
    rst       = 1'b0;
    fire_lvl  = (mode == 2) ? 1 : 0;
    if (rst_fs) begin
      model_reset();
      bus.fire = 1'b0;
      fire_lvl = 0;
    end else begin
      model_fsync(press, px, hfs);
    end
    check("slot_active", 32'(bus.slot_active), 32'(pack_act()));
    check("shots_fired", 32'(bus.shots_fired), 32'(m_shots));
    check("fire_accepted", 32'(bus.fire_accepted), 32'(m_acc));
    tick();
    check("fire_accepted_clear", 32'(bus.fire_accepted), 32'd0);
  endtask

  initial begin
    int mode;
    logic [NS-1:0] hmid, hfs;

    rst          = 1'b1;
    bus.fire     = 1'b0;
    bus.fsync    = 1'b0;
    bus.hit      = '0;
    bus.player_x = '0;
    bus.hpos     = '0;
    bus.vpos     = '0;
    fire_lvl     = 0;
    model_reset();
    repeat (3) tick();
    check("rst_slot_active", 32'(bus.slot_active), 32'd0);
    check("rst_shots", 32'(bus.shots_fired), 32'd0);
    check("rst_fire_accepted", 32'(bus.fire_accepted), 32'd0);
    check("rst_active", 32'(bus.active), 32'd0);
    rst = 1'b0;
    tick();

    // Idle frames: nothing may appear
    repeat (3) run_frame(0, 100, '0, '0, 1'b0);
    probe_at(0, 0, "idle_origin");

    // First press at player_x=320
    run_frame(1, 320, '0, '0, 1'b0);
    check("first_slot0", 32'(bus.slot_active), 32'd1);
    check("first_shots", 32'(bus.shots_fired), 32'd1);
    probe_at(320, SPAWN_Y, "spawn_centre");
    check("spawn_centre_color", 32'({bus.pixel[2], bus.pixel[1], bus.pixel[0]}), 32'(COLOR));
    probe_at(320 + HALF + 1, SPAWN_Y, "spawn_right_edge_out");
    probe_at(320 + HALF, SPAWN_Y + BH, "spawn_corner_in");

    // Randomized frames with presses, holds, mid-frame hits and fsync hits
    for (int f = 0; f < 220; f++) begin
      mode = int'($urandom_range(0, 2));
      hmid = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
      hfs  = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
      run_frame(mode, int'($urandom_range(0, 639)), hmid, hfs, f == 150);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
